// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the vending machine: FSM states, field widths
// and default product prices.
package vending_machine_pkg;

  localparam int CODE_W    = 2;
  localparam int COUNT_W   = 3;
  localparam int MONEY_W   = 4;
  localparam int TOTAL_W   = 7;
  localparam int PRICE_W   = 4;
  localparam int STOCK_W   = 4;
  localparam int NUM_CODES = 4;

  localparam int unsigned DEF_PRICE0     = 2;
  localparam int unsigned DEF_PRICE1     = 3;
  localparam int unsigned DEF_PRICE2     = 4;
  localparam int unsigned DEF_PRICE3     = 5;
  localparam int unsigned DEF_INIT_STOCK = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/vending_machine_price_calc.sv
// Combinational pricing for one captured request: price lookup, 7-bit total,
// affordability check and change.
module vm_price_calc
  import vending_machine_pkg::*;
#(
  parameter int unsigned PRICE0 = DEF_PRICE0,
  parameter int unsigned PRICE1 = DEF_PRICE1,
  parameter int unsigned PRICE2 = DEF_PRICE2,
  parameter int unsigned PRICE3 = DEF_PRICE3
) (
  input  logic [CODE_W-1:0]  code,
  input  logic [COUNT_W-1:0] count,
  input  logic [MONEY_W-1:0] money,
  output logic [TOTAL_W-1:0] total,
  output logic               money_ok,
  output logic [MONEY_W-1:0] change
);

  logic [PRICE_W-1:0] price;

  always_comb begin
    price = PRICE_W'(PRICE0);
    case (code)
      2'd0:    price = PRICE_W'(PRICE0);
      2'd1:    price = PRICE_W'(PRICE1);
      2'd2:    price = PRICE_W'(PRICE2);
      default: price = PRICE_W'(PRICE3);
    endcase
  end

  // Both operands widened first so 15*7 = 105 never truncates.
  assign total    = TOTAL_W'(price) * TOTAL_W'(count);
  assign money_ok = TOTAL_W'(money) >= total;
  // Only meaningful when money_ok, where total fits in MONEY_W bits.
  assign change   = money - total[MONEY_W-1:0];

endmodule

// File: rtl/vending_machine.sv
// Vending machine top: IDLE/CALC/RESULT FSM, request capture, result registers
// and per-product stock (stock compiled in only when VM_STOCK_EN is defined).
module vending_machine
  import vending_machine_pkg::*;
#(
  parameter int unsigned PRICE0     = DEF_PRICE0,
  parameter int unsigned PRICE1     = DEF_PRICE1,
  parameter int unsigned PRICE2     = DEF_PRICE2,
  parameter int unsigned PRICE3     = DEF_PRICE3,
  parameter int unsigned INIT_STOCK = DEF_INIT_STOCK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [CODE_W-1:0]  code,
  input  logic [COUNT_W-1:0] count,
  input  logic [MONEY_W-1:0] money,
  output logic               posibility,
  output logic [MONEY_W-1:0] remaining,
  output logic               done
);

  state_t state_reg, state_next;
  logic   capture;

  logic [CODE_W-1:0]  code_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [MONEY_W-1:0] money_reg;

  logic [TOTAL_W-1:0] total;
  logic               money_ok;
  logic [MONEY_W-1:0] change;
  logic               stock_ok;
  logic               accept;
  logic               vend;

  logic               posibility_reg;
  logic [MONEY_W-1:0] remaining_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        state_next = RESULT;
      end
      RESULT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Inputs are only looked at on the capturing edge; later changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg  <= '0;
      count_reg <= '0;
      money_reg <= '0;
    end else if (capture) begin
      code_reg  <= code;
      count_reg <= count;
      money_reg <= money;
    end
  end

  vm_price_calc #(
    .PRICE0 (PRICE0),
    .PRICE1 (PRICE1),
    .PRICE2 (PRICE2),
    .PRICE3 (PRICE3)
  ) u_price_calc (
    .code     (code_reg),
    .count    (count_reg),
    .money    (money_reg),
    .total    (total),
    .money_ok (money_ok),
    .change   (change)
  );

`ifdef VM_STOCK_EN
  logic [NUM_CODES-1:0][STOCK_W-1:0] stock_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CODES; gi++) begin : g_stock
      logic [STOCK_W-1:0] stock_reg;

      // A vend is only granted when stock covers count, so this cannot wrap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stock_reg <= STOCK_W'(INIT_STOCK);
        end else if (vend && (code_reg == CODE_W'(gi))) begin
          stock_reg <= stock_reg - STOCK_W'(count_reg);
        end
      end

      assign stock_vec[gi] = stock_reg;
    end
  endgenerate

  assign stock_ok = stock_vec[code_reg] >= STOCK_W'(count_reg);
`else
  assign stock_ok = 1'b1;
`endif

  assign accept = (count_reg != '0) && money_ok && stock_ok;
  assign vend   = (state_reg == CALC) && accept;

  // Results change only on the edge leaving CALC and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posibility_reg <= 1'b0;
      remaining_reg  <= '0;
    end else if (state_reg == CALC) begin
      posibility_reg <= accept;
      remaining_reg  <= accept ? change : money_reg;
    end
  end

  assign posibility = posibility_reg;
  assign remaining  = remaining_reg;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine; a reference model pushes expected
// results to a queue which is popped when done pulses.
module tb_vending_machine;

  localparam int INIT_STOCK = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] code;
  logic [2:0] count;
  logic [3:0] money;
  logic       posibility;
  logic [3:0] remaining;
  logic       done;

  vending_machine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .code       (code),
    .count      (count),
    .money      (money),
    .posibility (posibility),
    .remaining  (remaining),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pos;
    logic [3:0] rem;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   stock_m[4];
  int   price_m[4] = '{2, 3, 4, 5};

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) stock_m[i] = INIT_STOCK;
  endfunction

  function automatic void push_expected(int c, int n, int m);
    int   total;
    bit   ok;
    exp_t e;
    total = price_m[c] * n;
    ok    = (n != 0) && (m >= total);
`ifdef VM_STOCK_EN
    ok = ok && (stock_m[c] >= n);
    if (ok) stock_m[c] = stock_m[c] - n;
`endif
    e.pos = ok;
    e.rem = ok ? 4'(m - total) : 4'(m);
    exp_q.push_back(e);
  endfunction

  task automatic apply_reset();
    req   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one request, scrambles inputs afterwards, waits (bounded) for done.
  task automatic run_txn(input int c, input int n, input int m,
                         output logic got_pos, output logic [3:0] got_rem, output int lat);
    @(negedge clk);
    req   = 1'b1;
    code  = 2'(c);
    count = 3'(n);
    money = 4'(m);
    push_expected(c, n, m);
    @(negedge clk);
    req   = 1'b0;
    code  = 2'($urandom_range(3, 0));
    count = 3'($urandom_range(7, 0));
    money = 4'($urandom_range(15, 0));
    lat   = 1;
    while (done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    got_pos = posibility;
    got_rem = remaining;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    req   = 1'b1;
    code  = 2'd0;
    count = 3'd1;
    money = 4'd15;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (posibility !== 1'b0) begin n_fails++; $display("FAIL reset_posibility: got %b expected 0", posibility); end
    n_checks++; if (remaining !== 4'd0) begin n_fails++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
    n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    req   = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fails++; $display("FAIL reset_no_start: got %0d done pulses expected 0", seen); end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic p; logic [3:0] r; int lat; exp_t e;
    run_txn(0, 1, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 2) begin n_fails++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    n_checks++; if (p !== e.pos) begin n_fails++; $display("FAIL basic_pos: got %b expected %b", p, e.pos); end
    n_checks++; if (r !== 4'd13) begin n_fails++; $display("FAIL basic_rem: got %0d expected 13", r); end
    $display("txn code=0 count=1 money=15 -> pos=%b rem=%0d lat=%0d", p, r, lat);
  endtask

  task automatic test_sequential();
    logic p; logic [3:0] r; int lat; exp_t e;
    logic [3:0] want[3] = '{4'd12, 4'd11, 4'd10};
    for (int k = 0; k < 3; k++) begin
      run_txn(k + 1, 1, 15, p, r, lat);
      e = exp_q.pop_front();
      n_checks++; if (p !== 1'b1 || p !== e.pos) begin n_fails++; $display("FAIL seq_pos code=%0d: got %b expected 1", k + 1, p); end
      n_checks++; if (r !== want[k]) begin n_fails++; $display("FAIL seq_rem code=%0d: got %0d expected %0d", k + 1, r, want[k]); end
      $display("txn code=%0d count=1 money=15 -> pos=%b rem=%0d", k + 1, p, r);
    end
  endtask

  task automatic test_reject_money();
    logic p; logic [3:0] r; int lat; exp_t e;
    run_txn(3, 3, 14, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== 1'b0) begin n_fails++; $display("FAIL poor_pos: got %b expected 0", p); end
    n_checks++; if (r !== 4'd14) begin n_fails++; $display("FAIL poor_rem: got %0d expected 14", r); end
    $display("txn code=3 count=3 money=14 -> pos=%b rem=%0d", p, r);
    // Stock for code 3 must be untouched: this only fits with 4 left.
    run_txn(3, 3, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== e.pos || r !== e.rem) begin n_fails++; $display("FAIL poor_after: got pos=%b rem=%0d expected pos=%b rem=%0d", p, r, e.pos, e.rem); end
    $display("txn code=3 count=3 money=15 -> pos=%b rem=%0d", p, r);
  endtask

  task automatic test_boundaries();
    logic p; logic [3:0] r; int lat; exp_t e;
    apply_reset();
    run_txn(2, 0, 9, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== 1'b0) begin n_fails++; $display("FAIL zero_count_pos: got %b expected 0", p); end
    n_checks++; if (r !== 4'd9) begin n_fails++; $display("FAIL zero_count_rem: got %0d expected 9", r); end
    $display("txn code=2 count=0 money=9 -> pos=%b rem=%0d", p, r);
    run_txn(1, 5, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== 1'b1) begin n_fails++; $display("FAIL exact_pos: got %b expected 1", p); end
    n_checks++; if (r !== 4'd0) begin n_fails++; $display("FAIL exact_rem: got %0d expected 0", r); end
    $display("txn code=1 count=5 money=15 -> pos=%b rem=%0d", p, r);
  endtask

  task automatic test_stock();
    logic p; logic [3:0] r; int lat; exp_t e;
    apply_reset();
    run_txn(0, 5, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== 1'b1 || r !== 4'd5) begin n_fails++; $display("FAIL stock_first: got pos=%b rem=%0d expected pos=1 rem=5", p, r); end
    $display("txn code=0 count=5 money=15 -> pos=%b rem=%0d", p, r);
    run_txn(0, 5, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== e.pos || r !== e.rem) begin n_fails++; $display("FAIL stock_repeat: got pos=%b rem=%0d expected pos=%b rem=%0d", p, r, e.pos, e.rem); end
`ifdef VM_STOCK_EN
    n_checks++; if (p !== 1'b0 || r !== 4'd15) begin n_fails++; $display("FAIL stock_empty: got pos=%b rem=%0d expected pos=0 rem=15", p, r); end
`endif
    $display("txn code=0 count=5 money=15 -> pos=%b rem=%0d", p, r);
    apply_reset();
    run_txn(0, 6, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== e.pos || r !== e.rem) begin n_fails++; $display("FAIL stock_over: got pos=%b rem=%0d expected pos=%b rem=%0d", p, r, e.pos, e.rem); end
    $display("txn code=0 count=6 money=15 -> pos=%b rem=%0d", p, r);
    run_txn(0, 5, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== e.pos || r !== e.rem) begin n_fails++; $display("FAIL stock_nopartial: got pos=%b rem=%0d expected pos=%b rem=%0d", p, r, e.pos, e.rem); end
    $display("txn code=0 count=5 money=15 -> pos=%b rem=%0d", p, r);
  endtask

  task automatic test_ignore_req();
    exp_t e;
    int   seen;
    @(negedge clk);
    req = 1'b1; code = 2'd2; count = 3'd2; money = 4'd10;
    push_expected(2, 2, 10);
    @(negedge clk);
    code = 2'd3; count = 3'd1; money = 4'd15;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL ignore_done: got %b expected 1", done); end
    n_checks++; if (posibility !== e.pos || remaining !== e.rem) begin n_fails++; $display("FAIL ignore_result: got pos=%b rem=%0d expected pos=%b rem=%0d", posibility, remaining, e.pos, e.rem); end
    $display("txn code=2 count=2 money=10 (req held) -> pos=%b rem=%0d", posibility, remaining);
    @(negedge clk);
    req  = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fails++; $display("FAIL ignore_queued: got %0d extra done pulses expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic p; logic [3:0] r; int lat; exp_t e; int seen;
    @(negedge clk);
    req = 1'b1; code = 2'd0; count = 3'd5; money = 4'd15;
    push_expected(0, 5, 15);
    @(negedge clk);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (done !== 1'b0 || posibility !== 1'b0 || remaining !== 4'd0) begin n_fails++; $display("FAIL midreset_outputs: got done=%b pos=%b rem=%0d expected 0 0 0", done, posibility, remaining); end
    void'(exp_q.pop_back());
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fails++; $display("FAIL midreset_done: got %0d done pulses expected 0", seen); end
    run_txn(0, 5, 15, p, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (p !== 1'b1 || r !== 4'd5) begin n_fails++; $display("FAIL midreset_stock: got pos=%b rem=%0d expected pos=1 rem=5", p, r); end
    $display("txn after mid reset code=0 count=5 money=15 -> pos=%b rem=%0d", p, r);
  endtask

  task automatic test_back_to_back();
    logic p; logic [3:0] r; int lat; exp_t e; int c, n, m;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      c = $urandom_range(3, 0);
      n = $urandom_range(7, 0);
      m = $urandom_range(15, 0);
      run_txn(c, n, m, p, r, lat);
      e = exp_q.pop_front();
      n_checks++; if (lat !== 2) begin n_fails++; $display("FAIL b2b_latency #%0d: got %0d expected 2", k, lat); end
      n_checks++; if (p !== e.pos || r !== e.rem) begin n_fails++; $display("FAIL b2b_result #%0d: got pos=%b rem=%0d expected pos=%b rem=%0d", k, p, r, e.pos, e.rem); end
      $display("txn #%0d code=%0d count=%0d money=%0d -> pos=%b rem=%0d", k, c, n, m, p, r);
      if (k % 6 == 5) begin
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || posibility !== e.pos || remaining !== e.rem) begin n_fails++; $display("FAIL b2b_hold #%0d: got done=%b pos=%b rem=%0d expected done=0 pos=%b rem=%0d", k, done, posibility, remaining, e.pos, e.rem); end
      end
    end
  endtask

  initial begin
    req   = 1'b0;
    code  = 2'd0;
    count = 3'd0;
    money = 4'd0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_sequential();
    test_reject_money();
    test_boundaries();
    test_stock();
    test_ignore_req();
    test_reset_mid();
    test_back_to_back();
    n_checks++; if (exp_q.size() != 0) begin n_fails++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
